// File: rtl/tlc_ns_ctrl_pkg.sv
// Shared definitions for the left-turn traffic light controller: state codes,
// light codes, sensor bundle and small decode helpers.
package tlc_ns_ctrl_pkg;

  typedef enum logic [2:0] {
    S0 = 3'b000,  // A green
    S1 = 3'b001,  // A yellow (into left)
    S2 = 3'b010,  // A left
    S3 = 3'b011,  // A yellow (into B)
    S4 = 3'b100,  // B green
    S5 = 3'b101,  // B yellow (into left)
    S6 = 3'b110,  // B left
    S7 = 3'b111   // B yellow (into A)
  } state_e;

  localparam logic [1:0] LT_G = 2'b00;
  localparam logic [1:0] LT_Y = 2'b01;
  localparam logic [1:0] LT_L = 2'b10;
  localparam logic [1:0] LT_R = 2'b11;

  typedef struct packed {
    logic ta;
    logic tal;
    logic tb;
    logic tbl;
  } sens_t;

  // The phase order is a plain ring, so the successor is just +1 mod 8.
  function automatic state_e next_phase(state_e s);
    return state_e'(s + 3'd1);
  endfunction

  function automatic logic [1:0] light_a(state_e s);
    logic [1:0] lt;
    lt = LT_R;
    case (s)
      S0:      lt = LT_G;
      S1, S3:  lt = LT_Y;
      S2:      lt = LT_L;
      default: lt = LT_R;
    endcase
    return lt;
  endfunction

  function automatic logic [1:0] light_b(state_e s);
    logic [1:0] lt;
    lt = LT_R;
    case (s)
      S4:      lt = LT_G;
      S5, S7:  lt = LT_Y;
      S6:      lt = LT_L;
      default: lt = LT_R;
    endcase
    return lt;
  endfunction

endpackage

// File: rtl/tlc_ns_ctrl_sync.sv
// Two-flop synchroniser for the asynchronous traffic sensors; runs every clk,
// independent of the timing enable.
module tlc_sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/tlc_ns_ctrl.sv
// Next-state logic and state register for the 8-phase traffic light controller.
// Sensor demand only stretches or shortens dwell; the phase order never changes.
module tlc_ns_ctrl
  import tlc_ns_ctrl_pkg::*;
#(
  parameter int CNT_W   = 5,
  parameter int YEL_CYC = 3,
  parameter int MIN_GRN = 4,
  parameter int MIN_LFT = 2,
  parameter int MAX_GRN = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             Ta,
  input  logic             Tal,
  input  logic             Tb,
  input  logic             Tbl,
  output logic [2:0]       q,
  output logic             chg,
  output logic [CNT_W-1:0] tmr
);

  localparam logic [CNT_W-1:0] T_MIN_G = CNT_W'(MIN_GRN - 1);
  localparam logic [CNT_W-1:0] T_MIN_L = CNT_W'(MIN_LFT - 1);
  localparam logic [CNT_W-1:0] T_MAX   = CNT_W'(MAX_GRN - 1);
  localparam logic [CNT_W-1:0] T_YEL   = CNT_W'(YEL_CYC - 1);
  localparam logic [CNT_W-1:0] T_SAT   = {CNT_W{1'b1}};

  sens_t sens_raw;
  sens_t sens_s;

  assign sens_raw = {Ta, Tal, Tb, Tbl};

  tlc_sync2 #(.W(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sens_raw),
    .q     (sens_s)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic             chg_q, chg_d;
  logic             leave;
  logic             min_g, min_l, at_max;

  assign min_g  = (tmr_q >= T_MIN_G);
  assign min_l  = (tmr_q >= T_MIN_L);
  assign at_max = (tmr_q >= T_MAX);

  // Greens hold while own traffic remains, but yield at the limit only if
  // the other street is actually waiting; left phases yield at the limit regardless.
  always_comb begin
    leave = 1'b0;
    case (state_q)
      S0: leave = min_g && (!sens_s.ta  || (at_max && (sens_s.tb || sens_s.tbl)));
      S4: leave = min_g && (!sens_s.tb  || (at_max && (sens_s.ta || sens_s.tal)));
      S2: leave = min_l && (!sens_s.tal || at_max);
      S6: leave = min_l && (!sens_s.tbl || at_max);
      S1, S3, S5, S7: leave = (tmr_q == T_YEL);
    endcase
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    chg_d   = 1'b0;
    if (en) begin
      if (leave) begin
        state_d = next_phase(state_q);
        tmr_d   = '0;
        chg_d   = 1'b1;
      end else if (tmr_q != T_SAT) begin
        tmr_d = tmr_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0;
      tmr_q   <= '0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      chg_q   <= chg_d;
    end
  end

  assign q   = state_q;
  assign tmr = tmr_q;
  assign chg = chg_q;

endmodule
